// File: rtl/calculator_seq_if.sv
//------------------------------------------------------------------------------
// Module   : calculator_seq_if
// Purpose  : Request/response bundle between the operand capture logic
//            (master) and the sequential calculator (slave).
//            acc_sel is present only when CALC_SEQ_ACCUM_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface calculator_seq_if #(
  parameter int N = 4
);
  logic             start;
  logic [3:0]       op_select;
  logic [N-1:0]     operand1;
  logic [N-1:0]     operand2;
`ifdef CALC_SEQ_ACCUM_EN
  logic             acc_sel;
`endif
  logic             busy;
  logic             done;
  logic [2*N-1:0]   resultado;
  logic             carry;
  logic             zero;
  logic             div_by_zero;

  modport master (
`ifdef CALC_SEQ_ACCUM_EN
    output acc_sel,
`endif
    output start, op_select, operand1, operand2,
    input  busy, done, resultado, carry, zero, div_by_zero
  );

  modport slave (
`ifdef CALC_SEQ_ACCUM_EN
    input  acc_sel,
`endif
    input  start, op_select, operand1, operand2,
    output busy, done, resultado, carry, zero, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/calculator_seq.sv
//------------------------------------------------------------------------------
// Module   : calculator_seq
// Purpose  : Registered, handshaked N-bit calculator. Single-cycle ALU ops,
//            N-cycle shift-add multiply and N-cycle restoring divide/modulo,
//            with carry / zero / div_by_zero status flags.
//            Optional macro CALC_SEQ_ACCUM_EN adds acc_sel, which replaces
//            operand1 with the low half of the previous result.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module calculator_seq #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  calculator_seq_if.slave  bus
);

  localparam int            CW        = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
  localparam logic [N-1:0]  WIDTH_VAL = N'(N);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state;
  logic [3:0]      op;
  logic [N-1:0]    a;
  logic [N-1:0]    b;
  logic [CW-1:0]   step;
  logic [2*N-1:0]  mul_acc;
  logic [2*N-1:0]  mul_mcand;
  logic [N-1:0]    mul_mplier;
  logic [N-1:0]    div_rem;
  logic [N-1:0]    div_quo;

  logic            busy;
  logic            done;
  logic [2*N-1:0]  resultado;
  logic            carry;
  logic            zero;
  logic            div_by_zero;

  logic [3:0]      norm_op;
  logic [N-1:0]    op1_eff;
  logic [N:0]      sum;
  logic [N-1:0]    diff;
  logic [2*N-1:0]  exec_res;
  logic            exec_carry;
  logic [2*N-1:0]  mul_acc_next;
  logic [N:0]      div_shift;
  logic            div_fits;
  logic [N-1:0]    div_rem_next;
  logic [N-1:0]    div_quo_next;

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.resultado   = resultado;
  assign bus.carry       = carry;
  assign bus.zero        = zero;
  assign bus.div_by_zero = div_by_zero;

`ifdef CALC_SEQ_ACCUM_EN
  assign op1_eff = bus.acc_sel ? resultado[N-1:0] : bus.operand1;
`else
  assign op1_eff = bus.operand1;
`endif

  // Fold the alias opcodes 10..15 onto their primary encodings at capture.
  always_comb begin
    case (bus.op_select)
      4'd10:   norm_op = OP_AND;
      4'd11:   norm_op = OP_OR;
      4'd12:   norm_op = OP_XOR;
      4'd13:   norm_op = OP_SHL;
      4'd14:   norm_op = OP_SHR;
      4'd15:   norm_op = OP_ADD;
      default: norm_op = bus.op_select;
    endcase
  end

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = a - b;

  // Single-step result; also resolves divide/modulo by zero.
  always_comb begin
    exec_res   = '0;
    exec_carry = 1'b0;
    case (op)
      OP_ADD: begin
        exec_res[N:0] = sum;
        exec_carry    = sum[N];
      end
      OP_SUB: begin
        exec_res[N-1:0] = diff;
        exec_carry      = (b > a);
      end
      OP_DIV:  exec_res[N-1:0] = '1;
      OP_MOD:  exec_res[N-1:0] = a;
      OP_AND:  exec_res[N-1:0] = a & b;
      OP_OR:   exec_res[N-1:0] = a | b;
      OP_XOR:  exec_res[N-1:0] = a ^ b;
      OP_SHL:  exec_res[N-1:0] = (b >= WIDTH_VAL) ? '0 : (a << b);
      OP_SHR:  exec_res[N-1:0] = (b >= WIDTH_VAL) ? '0 : (a >> b);
      default: exec_res = '0;
    endcase
  end

  // One shift-add and one restoring-division step per cycle.
  assign mul_acc_next = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;
  assign div_shift    = {div_rem, div_quo[N-1]};
  assign div_fits     = (div_shift >= {1'b0, b});
  assign div_rem_next = div_fits ? (div_shift[N-1:0] - b) : div_shift[N-1:0];
  assign div_quo_next = {div_quo[N-2:0], div_fits};

  // Control FSM with registered handshake, result and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op          <= '0;
      a           <= '0;
      b           <= '0;
      step        <= '0;
      mul_acc     <= '0;
      mul_mcand   <= '0;
      mul_mplier  <= '0;
      div_rem     <= '0;
      div_quo     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      resultado   <= '0;
      carry       <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            op         <= norm_op;
            a          <= op1_eff;
            b          <= bus.operand2;
            step       <= '0;
            busy       <= 1'b1;
            mul_acc    <= '0;
            mul_mcand  <= {{N{1'b0}}, op1_eff};
            mul_mplier <= bus.operand2;
            div_rem    <= '0;
            div_quo    <= op1_eff;
            if (norm_op == OP_MUL) begin
              state <= S_MUL;
            end else if ((norm_op == OP_DIV || norm_op == OP_MOD) &&
                         (bus.operand2 != '0)) begin
              state <= S_DIV;
            end else begin
              // Divide by zero finishes through EXEC, so it shares the
              // two-cycle latency of the other single-step operations.
              state <= S_EXEC;
            end
          end
        end

        S_EXEC: begin
          resultado   <= exec_res;
          carry       <= exec_carry;
          zero        <= (exec_res == '0);
          div_by_zero <= (op == OP_DIV) || (op == OP_MOD);
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= S_DONE;
        end

        S_MUL: begin
          mul_acc    <= mul_acc_next;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          step       <= step + 1'b1;
          if (step == LAST_STEP) begin
            resultado   <= mul_acc_next;
            carry       <= 1'b0;
            zero        <= (mul_acc_next == '0);
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= S_DONE;
          end
        end

        S_DIV: begin
          div_rem <= div_rem_next;
          div_quo <= div_quo_next;
          step    <= step + 1'b1;
          if (step == LAST_STEP) begin
            if (op == OP_DIV) begin
              resultado <= {{N{1'b0}}, div_quo_next};
              zero      <= (div_quo_next == '0);
            end else begin
              resultado <= {{N{1'b0}}, div_rem_next};
              zero      <= (div_rem_next == '0);
            end
            carry       <= 1'b0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= S_DONE;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_calculator_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_calculator_seq
// Purpose  : Self-checking bench for calculator_seq (N=4): directed cases,
//            mid-operation reset, and randomized operations compared with an
//            arithmetic reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_calculator_seq;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  calculator_seq_if #(.N(N)) bus ();

  calculator_seq #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: result, carry, div_by_zero and latency straight from the op rules.
  function automatic void model(input int opc, input int x, input int y,
                                output int res, output int cy, output int dz,
                                output int lat);
    int o;
    int m;
    m = 1 << N;
    case (opc)
      10: o = 5;
      11: o = 6;
      12: o = 7;
      13: o = 8;
      14: o = 9;
      15: o = 0;
      default: o = opc;
    endcase
    res = 0; cy = 0; dz = 0; lat = 2;
    case (o)
      0: begin res = x + y; cy = ((x + y) >= m) ? 1 : 0; end
      1: begin res = (x - y + m) % m; cy = (y > x) ? 1 : 0; end
      2: begin res = x * y; lat = N + 1; end
      3: if (y == 0) begin res = m - 1; dz = 1; end
         else begin res = x / y; lat = N + 1; end
      4: if (y == 0) begin res = x; dz = 1; end
         else begin res = x % y; lat = N + 1; end
      5: res = x & y;
      6: res = x | y;
      7: res = x ^ y;
      8: res = (y >= N) ? 0 : ((x << y) % m);
      9: res = (y >= N) ? 0 : (x >> y);
      default: res = 0;
    endcase
  endfunction

  task automatic do_op(input int opc, input int x, input int y, input bit poke);
    int  er, ec, ed, el;
    int  cyc;
    bit  seen;
    model(opc, x, y, er, ec, ed, el);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.op_select = 4'(opc);
    bus.operand1  = N'(x);
    bus.operand2  = N'(y);
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= 40) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        check("busy_during_op", bus.busy, 1);
        if (poke && cyc == 2) begin
          bus.start     = 1'b1;
          bus.op_select = 4'd0;
          bus.operand1  = '1;
          bus.operand2  = '1;
        end else begin
          bus.start = 1'b0;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    bus.start = 1'b0;
    check($sformatf("done_seen op%0d", opc), seen, 1);
    check($sformatf("latency op%0d %0d,%0d", opc, x, y), cyc, el);
    check($sformatf("result op%0d %0d,%0d", opc, x, y), bus.resultado, er);
    check($sformatf("carry op%0d", opc), bus.carry, ec);
    check($sformatf("zero op%0d", opc), bus.zero, (er == 0) ? 1 : 0);
    check($sformatf("dbz op%0d", opc), bus.div_by_zero, ed);
    check("busy_at_done", bus.busy, 0);
    @(posedge clk); #1;
    check("done_single_pulse", bus.done, 0);
    check("result_holds", bus.resultado, er);
    if (poke) begin
      @(posedge clk); #1;
      check("no_queued_start", bus.busy | bus.done, 0);
    end
  endtask

  initial begin
    int dones;
    bus.start     = 1'b0;
    bus.op_select = '0;
    bus.operand1  = '0;
    bus.operand2  = '0;
`ifdef CALC_SEQ_ACCUM_EN
    bus.acc_sel   = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.resultado, 0);
    check("rst_flags", {bus.carry, bus.zero, bus.div_by_zero}, 0);

    // Directed cases
    do_op(0, 9, 8, 0);
    do_op(1, 3, 5, 0);
    do_op(1, 5, 5, 0);
    do_op(2, 15, 15, 1);
    do_op(3, 13, 4, 0);
    do_op(4, 13, 4, 0);
    do_op(3, 7, 0, 0);
    do_op(4, 7, 0, 0);
    do_op(8, 3, 2, 0);
    do_op(9, 12, 5, 0);
    do_op(15, 1, 1, 0);
    do_op(10, 12, 10, 0);
    do_op(14, 8, 3, 0);
    do_op(13, 15, 4, 0);

    // Reset during the second cycle of a divide
    do_op(0, 9, 8, 0);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.op_select = 4'd3;
    bus.operand1  = N'(13);
    bus.operand2  = N'(4);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_result", bus.resultado, 0);
    check("midrst_flags", {bus.carry, bus.zero, bus.div_by_zero}, 0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (N + 4) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("midrst_no_done", dones, 0);
    do_op(5, 6, 3, 0);

    // Randomized operations against the model
    for (int i = 0; i < 80; i++) begin
      int opc, x, y;
      opc = int'($urandom_range(0, 15));
      x   = int'($urandom_range(0, 15));
      y   = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 15));
      do_op(opc, x, y, ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
